// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver: parity modes,
// the common TX/RX state encoding and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Callers zero-extend narrower payloads; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [31:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// Host-side and serial-side signals of the transceiver, plus FSM state
// exposed for observation.
interface uart_xcvr_param_if #(
    parameter int DATA_BITS = 8
);
    import uart_pkg::*;

    // TX handshake: a word transfers on a clock edge where tx_data_valid and
    // tx_ready are both high; tx_byte must be stable in that cycle only.
    logic                 tx_data_valid;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx_ready;
    logic                 tx_active;
    logic                 tx_serial;
    logic                 tx_done;
    logic                 rx_serial;
    logic                 rx_data_valid;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    state_t               tx_state;
    state_t               rx_state;

    modport master (
        output tx_data_valid, tx_byte, rx_serial,
        input  tx_ready, tx_active, tx_serial, tx_done,
        input  rx_data_valid, rx_byte, rx_parity_err, rx_frame_err,
        input  tx_state, rx_state
    );

    modport slave (
        input  tx_data_valid, tx_byte, rx_serial,
        output tx_ready, tx_active, tx_serial, tx_done,
        output rx_data_valid, rx_byte, rx_parity_err, rx_frame_err,
        output tx_state, rx_state
    );

endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: two-flop synchroniser, mid-bit sampling FSM and per-frame
// parity/framing error flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 86,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0
) (
    input  logic                 iclk,
    input  logic                 irst,
    input  logic                 serial,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output state_t               state
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic                 sync1, sync2;
    state_t               state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 par, par_n;
    logic                 valid_n, perr_n, ferr_n;

    always_ff @(posedge iclk) begin
        if (irst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= serial;
            sync2      <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            par        <= par_n;
            data_valid <= valid_n;
            data       <= data_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        valid_n = 1'b0;
        data_n  = data;
        perr_n  = parity_err;
        ferr_n  = frame_err;
        case (state)
            ST_IDLE: begin
                if (!sync2) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_START: begin
                // A line that is high again at mid-start-bit was a glitch.
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {sync2, shreg[DATA_BITS-1:1]};
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_PARITY: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    par_n   = sync2;
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                // Leave for IDLE at the stop sample so the next start edge is not missed.
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    valid_n = 1'b1;
                    data_n  = shreg;
                    perr_n  = (PARITY_MODE != PARITY_NONE) &&
                              (parity_bit(32'(shreg), PARITY_MODE) != par);
                    ferr_n  = !sync2;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART transceiver: TX framing FSM here, receiver in uart_rx_frame.
// Data width, parity mode and stop-bit count are parameters.
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 86,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           iclk,
    input  logic           irst,
    uart_xcvr_param_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 32 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_xcvr_param: illegal parameter combination");
    end

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par, par_n;
    logic                 done, done_n;
    logic                 bit_end;
    logic                 serial;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            par   <= par_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.tx_data_valid) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                    idx_n   = '0;
                    shreg_n = bus.tx_byte;
                    par_n   = parity_bit(32'(bus.tx_byte), PARITY_MODE);
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                // idx counts stop bits here; the frame ends after the last one.
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IW'(STOP_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        serial = 1'b1;
        case (state)
            ST_START:  serial = 1'b0;
            ST_DATA:   serial = shreg[0];
            ST_PARITY: serial = par;
            default:   serial = 1'b1;
        endcase
    end

    assign bus.tx_ready  = (state == ST_IDLE);
    assign bus.tx_active = (state != ST_IDLE);
    assign bus.tx_serial = serial;
    assign bus.tx_done   = done;
    assign bus.tx_state  = state;

    uart_rx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY_MODE  (PARITY_MODE)
    ) u_rx (
        .iclk       (iclk),
        .irst       (irst),
        .serial     (bus.rx_serial),
        .data_valid (bus.rx_data_valid),
        .data       (bus.rx_byte),
        .parity_err (bus.rx_parity_err),
        .frame_err  (bus.rx_frame_err),
        .state      (bus.rx_state)
    );

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param: three loopback instances (8N1, 8E1, 32N2) with
// line fault injection, table-driven frames and an RX scoreboard.
module tb_uart_xcvr_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_xcvr_param_if #(.DATA_BITS(8))  if_a ();
    uart_xcvr_param_if #(.DATA_BITS(8))  if_b ();
    uart_xcvr_param_if #(.DATA_BITS(32)) if_c ();

    uart_xcvr_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
        dut_a (.iclk(clk), .irst(rst), .bus(if_a));
    uart_xcvr_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1))
        dut_b (.iclk(clk), .irst(rst), .bus(if_b));
    uart_xcvr_param #(.CLKS_PER_BIT(8), .DATA_BITS(32), .PARITY_MODE(0), .STOP_BITS(2))
        dut_c (.iclk(clk), .irst(rst), .bus(if_c));

    logic force_stop_a = 1'b0;
    logic glitch_a     = 1'b0;
    logic inv_par_b    = 1'b0;

    assign if_a.rx_serial = if_a.tx_serial & ~(force_stop_a && if_a.tx_state == ST_STOP) & ~glitch_a;
    assign if_b.rx_serial = if_b.tx_serial ^ (inv_par_b && if_b.tx_state == ST_PARITY);
    assign if_c.rx_serial = if_c.tx_serial;

    int n_checks = 0;
    int n_errors = 0;
    int pulses_a = 0;
    int dones_a  = 0;

    // Scoreboard entries are {parity_err, frame_err, payload}.
    logic [9:0]  exp_q_a[$];
    logic [9:0]  exp_q_b[$];
    logic [33:0] exp_q_c[$];

    typedef struct {
        logic [7:0] data;
        int         exp_len;
    } vec_a_t;

    typedef struct {
        logic [7:0] data;
        logic       inv_par;
        logic       exp_par;
        logic       exp_perr;
    } vec_b_t;

    vec_a_t vec_a[6];
    vec_b_t vec_b[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: rx_data_valid with empty expected queue", name);
    endtask

    always @(negedge clk) begin
        if (if_a.tx_done) dones_a++;
        if (if_a.rx_data_valid) begin
            pulses_a++;
            if (exp_q_a.size() == 0) unexpected("a_rx");
            else check("a_rx", {if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_byte}, exp_q_a.pop_front());
        end
        if (if_b.rx_data_valid) begin
            if (exp_q_b.size() == 0) unexpected("b_rx");
            else check("b_rx", {if_b.rx_parity_err, if_b.rx_frame_err, if_b.rx_byte}, exp_q_b.pop_front());
        end
        if (if_c.rx_data_valid) begin
            if (exp_q_c.size() == 0) unexpected("c_rx");
            else check("c_rx", {if_c.rx_parity_err, if_c.rx_frame_err, if_c.rx_byte}, exp_q_c.pop_front());
        end
    end

    task automatic send_a(input logic [7:0] d, input logic exp_ferr, input int exp_len);
        int n;
        n = 0;
        while (!if_a.tx_ready && n < 1000) begin @(negedge clk); n++; end
        if_a.tx_data_valid = 1'b1;
        if_a.tx_byte       = d;
        exp_q_a.push_back({1'b0, exp_ferr, d});
        @(negedge clk);
        if_a.tx_data_valid = 1'b0;
        if_a.tx_byte       = ~d;
        check("a_active", if_a.tx_active, 1);
        check("a_ready_low", if_a.tx_ready, 0);
        n = 0;
        while (!if_a.tx_done && n < 1000) begin @(negedge clk); n++; end
        check("a_frame_len", n, exp_len);
    endtask

    task automatic send_b(input vec_b_t v);
        int   n;
        logic par_seen;
        par_seen  = 1'bx;
        inv_par_b = v.inv_par;
        n = 0;
        while (!if_b.tx_ready && n < 1000) begin @(negedge clk); n++; end
        if_b.tx_data_valid = 1'b1;
        if_b.tx_byte       = v.data;
        exp_q_b.push_back({v.exp_perr, 1'b0, v.data});
        @(negedge clk);
        if_b.tx_data_valid = 1'b0;
        n = 0;
        while (!if_b.tx_done && n < 1000) begin
            if (if_b.tx_state == ST_PARITY) par_seen = if_b.tx_serial;
            @(negedge clk);
            n++;
        end
        check("b_frame_len", n, 88);
        check("b_line_parity", par_seen, v.exp_par);
        repeat (4) @(negedge clk);
        inv_par_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, d0;
        vec_a[0] = '{8'hA5, 80};
        vec_a[1] = '{8'h00, 80};
        vec_a[2] = '{8'hFF, 80};
        vec_a[3] = '{8'h5A, 80};
        vec_a[4] = '{8'h80, 80};
        vec_a[5] = '{8'($urandom_range(0, 255)), 80};
        vec_b[0] = '{8'h07, 1'b0, 1'b1, 1'b0};
        vec_b[1] = '{8'h07, 1'b1, 1'b1, 1'b1};
        vec_b[2] = '{8'h00, 1'b0, 1'b0, 1'b0};
        vec_b[3] = '{8'hFF, 1'b0, 1'b0, 1'b0};
        vec_b[4] = '{8'h80, 1'b1, 1'b1, 1'b1};
        vec_b[5] = '{8'h3C, 1'b0, 1'b0, 1'b0};

        if_a.tx_data_valid = 1'b0; if_a.tx_byte = '0;
        if_b.tx_data_valid = 1'b0; if_b.tx_byte = '0;
        if_c.tx_data_valid = 1'b0; if_c.tx_byte = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_serial", if_a.tx_serial, 1);
        check("rst_tx_ready", if_a.tx_ready, 1);
        check("rst_tx_active", if_a.tx_active, 0);
        check("rst_tx_done", if_a.tx_done, 0);
        check("rst_rx_valid", if_a.rx_data_valid, 0);
        check("rst_rx_byte", if_a.rx_byte, 0);
        check("rst_rx_perr", if_a.rx_parity_err, 0);
        check("rst_rx_ferr", if_a.rx_frame_err, 0);
        check("rst_c_ready", if_c.tx_ready, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 8N1 frames, 80 cycles from first start-bit cycle to tx_done
        for (int i = 0; i < 6; i++) begin
            send_a(vec_a[i].data, 1'b0, vec_a[i].exp_len);
            repeat (3) @(negedge clk);
        end

        // Even parity, with the parity bit inverted on the line for some rows
        for (int i = 0; i < 6; i++) send_b(vec_b[i]);

        // Stop bit forced low: framing error, exactly one pulse
        p0 = pulses_a;
        force_stop_a = 1'b1;
        send_a(8'hC3, 1'b1, 80);
        repeat (30) @(negedge clk);
        force_stop_a = 1'b0;
        check("a_ferr_pulses", pulses_a - p0, 1);

        // Two-cycle glitch: RX enters START, rejects it, no pulse
        p0 = pulses_a;
        glitch_a = 1'b1;
        repeat (2) @(negedge clk);
        glitch_a = 1'b0;
        repeat (3) @(negedge clk);
        check("a_glitch_start", if_a.rx_state, ST_START);
        repeat (20) @(negedge clk);
        check("a_glitch_idle", if_a.rx_state, ST_IDLE);
        check("a_glitch_pulses", pulses_a - p0, 0);

        // 32-bit, 2 stop bits, valid held high: back-to-back frames
        if_c.tx_data_valid = 1'b1;
        if_c.tx_byte       = 32'hDEADBEEF;
        exp_q_c.push_back({2'b00, 32'hDEADBEEF});
        @(negedge clk);
        check("c_active1", if_c.tx_active, 1);
        if_c.tx_byte = 32'h12345678;
        n = 0;
        while (!if_c.tx_done && n < 1000) begin @(negedge clk); n++; end
        check("c_frame1_len", n, 280);
        check("c_ready_on_done", if_c.tx_ready, 1);
        exp_q_c.push_back({2'b00, 32'h12345678});
        @(negedge clk);
        check("c_active2", if_c.tx_active, 1);
        if_c.tx_data_valid = 1'b0;
        n = 0;
        while (!if_c.tx_done && n < 1000) begin @(negedge clk); n++; end
        check("c_frame2_len", n, 280);
        repeat (10) @(negedge clk);
        check("c_idle_after", if_c.tx_ready, 1);

        // Reset mid-DATA aborts the frame on both paths
        p0 = pulses_a;
        d0 = dones_a;
        if_a.tx_data_valid = 1'b1;
        if_a.tx_byte       = 8'h99;
        @(negedge clk);
        if_a.tx_data_valid = 1'b0;
        n = 0;
        while (if_a.tx_state != ST_DATA && n < 100) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        check("a_mid_data", if_a.tx_state, ST_DATA);
        rst = 1'b1;
        @(negedge clk);
        check("a_rst_serial", if_a.tx_serial, 1);
        check("a_rst_ready", if_a.tx_ready, 1);
        check("a_rst_active", if_a.tx_active, 0);
        check("a_rst_rx_idle", if_a.rx_state, ST_IDLE);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("a_abort_dones", dones_a - d0, 0);
        check("a_abort_pulses", pulses_a - p0, 0);
        send_a(8'h3C, 1'b0, 80);
        repeat (10) @(negedge clk);
        check("a_after_rst_pulses", pulses_a - p0, 1);

        check("a_queue_empty", exp_q_a.size(), 0);
        check("b_queue_empty", exp_q_b.size(), 0);
        check("c_queue_empty", exp_q_c.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
